// File: rtl/lmsm_sequencer_if.sv
// Decode-side handshake between Pipe1 and the LM/SM micro-op sequencer.
// Field widths follow REG_AW (mask width is 2**REG_AW).
interface lmsm_sequencer_if #(
  parameter int unsigned REG_AW = 3
);
  logic [15:0]       ir_in;
  logic              ir_valid;
  logic              downstream_stall;
  logic              flush;
  logic              busy;
  logic              uop_valid;
  logic              uop_is_store;
  logic [REG_AW-1:0] uop_base;
  logic [REG_AW-1:0] uop_reg;
  logic [REG_AW:0]   uop_offset;
  logic              uop_last;
  logic              uop_wb_base;

  modport master (
    output ir_in, ir_valid, downstream_stall, flush,
    input  busy, uop_valid, uop_is_store, uop_base, uop_reg, uop_offset, uop_last,
           uop_wb_base
  );

  modport slave (
    input  ir_in, ir_valid, downstream_stall, flush,
    output busy, uop_valid, uop_is_store, uop_base, uop_reg, uop_offset, uop_last,
           uop_wb_base
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM into one register-transfer micro-op per cycle, ascending from R0.
// Define LMSM_BASE_WB_EN to append a base-writeback micro-op to every sequence.
module lmsm_sequencer #(
  parameter int unsigned REG_AW = 3,
  parameter logic [3:0]  OPC_LM = 4'b0110,
  parameter logic [3:0]  OPC_SM = 4'b0111
) (
  input logic             clk,
  input logic             reset,
  lmsm_sequencer_if.slave bus
);

  localparam int unsigned MaskW = 2 ** REG_AW;
  localparam logic [MaskW-1:0] MaskOne = MaskW'(1);
  localparam logic [REG_AW:0]  OffOne  = (REG_AW + 1)'(1);

`ifdef LMSM_BASE_WB_EN
  localparam logic WbEn = 1'b1;
`else
  localparam logic WbEn = 1'b0;
`endif

  typedef enum logic {StIdle, StSeq} state_e;

  state_e              state_q, state_d;
  logic [MaskW-1:0]    mask_q, mask_d;
  logic [REG_AW-1:0]   base_q, base_d;
  logic                store_q, store_d;
  logic [REG_AW:0]     offset_q, offset_d;
  logic                wb_pend_q, wb_pend_d;

  logic [3:0]          ir_opc;
  logic [MaskW-1:0]    ir_mask;
  logic [REG_AW-1:0]   ir_base;
  logic                accept, advance, in_seq;
  logic                mask_nz, one_left, last_xfer, wb_uop, uop_last_c;
  logic [REG_AW-1:0]   low_idx;
  logic                unused_ir;

  assign ir_opc    = bus.ir_in[15:12];
  assign ir_mask   = bus.ir_in[MaskW-1:0];
  assign ir_base   = bus.ir_in[9 +: REG_AW];
  assign unused_ir = bus.ir_in[8];

  assign in_seq  = (state_q == StSeq);
  assign accept  = (state_q == StIdle) && bus.ir_valid &&
                   ((ir_opc == OPC_LM) || (ir_opc == OPC_SM)) &&
                   !bus.downstream_stall && !bus.flush;
  assign advance = !bus.downstream_stall && !bus.flush;

  assign mask_nz   = |mask_q;
  assign one_left  = mask_nz && ((mask_q & (mask_q - MaskOne)) == '0);
  assign last_xfer = one_left && !wb_pend_q;
  // Empty remaining mask with writeback still owed means the writeback micro-op is up.
  assign wb_uop     = in_seq && !mask_nz && wb_pend_q;
  assign uop_last_c = in_seq && (wb_uop || last_xfer);

  always_comb begin
    low_idx = '0;
    for (int i = MaskW - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = REG_AW'(i);
    end
  end

  always_comb begin
    bus.uop_valid    = in_seq && !bus.flush;
    bus.uop_is_store = in_seq && store_q;
    bus.uop_base     = in_seq ? base_q : '0;
    bus.uop_reg      = wb_uop ? base_q : (in_seq ? low_idx : '0);
    bus.uop_offset   = in_seq ? offset_q : '0;
    bus.uop_last     = uop_last_c;
`ifdef LMSM_BASE_WB_EN
    bus.uop_wb_base  = wb_uop;
`else
    bus.uop_wb_base  = 1'b0;
`endif
    if (in_seq) begin
      bus.busy = !bus.flush && !(advance && uop_last_c);
    end else begin
      bus.busy = accept && ((ir_mask != '0) || WbEn);
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    base_d    = base_q;
    store_d   = store_q;
    offset_d  = offset_q;
    wb_pend_d = wb_pend_q;
    if (bus.flush) begin
      state_d   = StIdle;
      mask_d    = '0;
      wb_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A zero mask without writeback is consumed here and never enters StSeq.
          if (accept && ((ir_mask != '0) || WbEn)) begin
            state_d   = StSeq;
            mask_d    = ir_mask;
            base_d    = ir_base;
            store_d   = (ir_opc == OPC_SM);
            offset_d  = '0;
            wb_pend_d = WbEn;
          end
        end
        StSeq: begin
          if (advance) begin
            if (wb_uop) begin
              wb_pend_d = 1'b0;
              state_d   = StIdle;
            end else begin
              mask_d   = mask_q & (mask_q - MaskOne);
              offset_d = offset_q + OffOne;
              if (last_xfer) state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      base_q    <= '0;
      store_q   <= 1'b0;
      offset_q  <= '0;
      wb_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      base_q    <= base_d;
      store_q   <= store_d;
      offset_q  <= offset_d;
      wb_pend_q <= wb_pend_d;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer; expectations follow LMSM_BASE_WB_EN when defined.
module tb_lmsm_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  lmsm_sequencer_if #(.REG_AW(3)) bus ();

  lmsm_sequencer #(.REG_AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Packed view: busy, valid, store, wb, last, base[2:0], reg[2:0], offset[3:0]
  logic [15:0] obs;
  assign obs = {bus.busy, bus.uop_valid, bus.uop_is_store, bus.uop_wb_base, bus.uop_last,
                bus.uop_base, bus.uop_reg, bus.uop_offset};

  function automatic logic [15:0] ex(input logic b, input logic v, input logic s,
                                     input logic w, input logic l, input logic [2:0] base,
                                     input logic [2:0] rg, input logic [3:0] off);
    return {b, v, s, w, l, base, rg, off};
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic drive(input logic [15:0] ir, input logic v, input logic st, input logic fl);
    bus.ir_in            = ir;
    bus.ir_valid         = v;
    bus.downstream_stall = st;
    bus.flush            = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("reset_async", obs, 16'h0000);
    tick();
    chk("reset_held", obs, 16'h0000);
    reset = 1'b0;

    // LM RA=R2 mask A5
    tick();
    drive(16'h64A5, 1'b1, 1'b0, 1'b0);
    chk("t1_accept", obs, ex(1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("t1_r0", obs, ex(1, 1, 0, 0, 0, 2, 0, 0));
    tick();
    chk("t1_r2", obs, ex(1, 1, 0, 0, 0, 2, 2, 1));
    tick();
    chk("t1_r5", obs, ex(1, 1, 0, 0, 0, 2, 5, 2));
    tick();
`ifdef LMSM_BASE_WB_EN
    chk("t1_r7", obs, ex(1, 1, 0, 0, 0, 2, 7, 3));
    tick();
    chk("t1_wb", obs, ex(0, 1, 0, 1, 1, 2, 2, 4));
`else
    chk("t1_r7_last", obs, ex(0, 1, 0, 0, 1, 2, 7, 3));
`endif
    tick();
    chk("t1_idle", obs, 16'h0000);

    // SM mask 00, then ADI
    drive(16'h7000, 1'b1, 1'b0, 1'b0);
`ifdef LMSM_BASE_WB_EN
    chk("t2_accept", obs, ex(1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    drive(16'h0123, 1'b1, 1'b0, 1'b0);
    chk("t2_wb_only", obs, ex(0, 1, 1, 1, 1, 0, 0, 0));
`else
    chk("t2_zero_mask", obs, 16'h0000);
    tick();
    drive(16'h0123, 1'b1, 1'b0, 1'b0);
    chk("t2_adi", obs, 16'h0000);
`endif
    tick();
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("t2_idle", obs, 16'h0000);

    // LM RA=R1 mask 81 with two stall cycles
    drive(16'h6281, 1'b1, 1'b0, 1'b0);
    chk("t3_accept", obs, ex(1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    chk("t3_stall1", obs, ex(1, 1, 0, 0, 0, 1, 0, 0));
    tick();
    chk("t3_stall2", obs, ex(1, 1, 0, 0, 0, 1, 0, 0));
    tick();
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("t3_r0", obs, ex(1, 1, 0, 0, 0, 1, 0, 0));
    tick();
`ifdef LMSM_BASE_WB_EN
    chk("t3_r7", obs, ex(1, 1, 0, 0, 0, 1, 7, 1));
    tick();
    chk("t3_wb", obs, ex(0, 1, 0, 1, 1, 1, 1, 2));
`else
    chk("t3_r7_last", obs, ex(0, 1, 0, 0, 1, 1, 7, 1));
`endif
    tick();
    chk("t3_idle", obs, 16'h0000);

    // SM RA=R3 mask FF, flush on third micro-op
    drive(16'h76FF, 1'b1, 1'b0, 1'b0);
    chk("t4_accept", obs, ex(1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("t4_r0", obs, ex(1, 1, 1, 0, 0, 3, 0, 0));
    tick();
    chk("t4_r1", obs, ex(1, 1, 1, 0, 0, 3, 1, 1));
    tick();
    drive(16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t4_flush_valid", {15'd0, bus.uop_valid}, 16'h0000);
    chk("t4_flush_busy", {15'd0, bus.busy}, 16'h0000);
    tick();
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("t4_idle", obs, 16'h0000);
    tick();
    drive(16'h6403, 1'b1, 1'b0, 1'b0);
    chk("t4_new_accept", obs, ex(1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("t4_new_r0", obs, ex(1, 1, 0, 0, 0, 2, 0, 0));
    tick();
`ifdef LMSM_BASE_WB_EN
    chk("t4_new_r1", obs, ex(1, 1, 0, 0, 0, 2, 1, 1));
    tick();
    chk("t4_new_wb", obs, ex(0, 1, 0, 1, 1, 2, 2, 2));
`else
    chk("t4_new_r1_last", obs, ex(0, 1, 0, 0, 1, 2, 1, 1));
`endif
    tick();
    chk("t4_new_idle", obs, 16'h0000);

    // LM RA=R5 mask 0F, reset after R1
    drive(16'h6A0F, 1'b1, 1'b0, 1'b0);
    chk("t5_accept", obs, ex(1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("t5_r0", obs, ex(1, 1, 0, 0, 0, 5, 0, 0));
    tick();
    chk("t5_r1", obs, ex(1, 1, 0, 0, 0, 5, 1, 1));
    #2;
    reset = 1'b1;
    #1;
    chk("t5_reset_async", obs, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_idle", obs, 16'h0000);

    // LM RA=R6 mask 0F; another LM on ir_in during the sequence is ignored
    drive(16'h6C0F, 1'b1, 1'b0, 1'b0);
    chk("t6_accept", obs, ex(1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    drive(16'h64A5, 1'b1, 1'b0, 1'b0);
    chk("t6_r0", obs, ex(1, 1, 0, 0, 0, 6, 0, 0));
    tick();
    chk("t6_r1", obs, ex(1, 1, 0, 0, 0, 6, 1, 1));
    tick();
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("t6_r2", obs, ex(1, 1, 0, 0, 0, 6, 2, 2));
    tick();
`ifdef LMSM_BASE_WB_EN
    chk("t6_r3", obs, ex(1, 1, 0, 0, 0, 6, 3, 3));
    tick();
    chk("t6_wb", obs, ex(0, 1, 0, 1, 1, 6, 6, 4));
`else
    chk("t6_r3_last", obs, ex(0, 1, 0, 0, 1, 6, 3, 3));
`endif
    tick();
    chk("t6_idle", obs, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
